game_timer: RTL and testbench

- Receiving end of the divided-clock interface: consumes the slow game_clk and display_clk square waves produced by the board clock divider.
- Synchronises both waves into the board clock domain and converts each rising edge into a single-cycle tick.
- Uses the ticks to run the memory game's round countdown (start / pause / timeout) and a blink phase for the display logic.
- Sits between the clock divider and the game FSM / 7-seg display driver; everything runs on the board clock, and no slow clock is used as a clock.

---
 rtl/game_timer.sv | 135 +++++++++++++
 tb/tb_game_timer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Round countdown and blink phase for the memory game, driven by ticks
// recovered from the divider's slow game_clk / display_clk square waves.
module game_timer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIME_LIMIT  = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             game_clk,
  input  logic             display_clk,
  input  logic             start,
  input  logic             pause,
  output logic             game_tick,
  output logic             display_tick,
  output logic [CNT_W-1:0] time_left,
  output logic             running,
  output logic             timeout,
  output logic             blink
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIME_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_TIMEOUT
  } state_t;

  logic [SYNC_STAGES-1:0] game_sync;
  logic [SYNC_STAGES-1:0] disp_sync;
  logic                   game_hist;
  logic                   disp_hist;
  state_t                 state;

  // Synchronisers plus one history flop each for rising-edge detection
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      game_sync <= '0;
      disp_sync <= '0;
      game_hist <= 1'b0;
      disp_hist <= 1'b0;
    end else begin
      game_sync <= {game_sync[SYNC_STAGES-2:0], game_clk};
      disp_sync <= {disp_sync[SYNC_STAGES-2:0], display_clk};
      game_hist <= game_sync[SYNC_STAGES-1];
      disp_hist <= disp_sync[SYNC_STAGES-1];
    end
  end

  // Pure AND of two flops, so the tick is glitch-free and exactly one cycle wide
  assign game_tick    = game_sync[SYNC_STAGES-1] & ~game_hist;
  assign display_tick = disp_sync[SYNC_STAGES-1] & ~disp_hist;

  // Round FSM; every output is updated together with the state it reflects
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      time_left <= LIMIT;
      running   <= 1'b0;
      timeout   <= 1'b0;
      blink     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          time_left <= LIMIT;
          blink     <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        ST_RUN: begin
          if (start) begin
            time_left <= LIMIT;
          end else if (pause) begin
            state   <= ST_PAUSED;
            running <= 1'b0;
            blink   <= 1'b0;
          end else if (game_tick) begin
            if (time_left > ONE) begin
              time_left <= time_left - ONE;
            end else begin
              time_left <= '0;
              state     <= ST_TIMEOUT;
              running   <= 1'b0;
              timeout   <= 1'b1;
              blink     <= 1'b0;
            end
          end
        end

        ST_PAUSED: begin
          if (start || !pause) begin
            if (start) begin
              time_left <= LIMIT;
            end
            state   <= ST_RUN;
            running <= 1'b1;
            blink   <= 1'b0;
          end else if (display_tick) begin
            blink <= ~blink;
          end
        end

        ST_TIMEOUT: begin
          if (start) begin
            state     <= ST_RUN;
            time_left <= LIMIT;
            running   <= 1'b1;
            timeout   <= 1'b0;
            blink     <= 1'b0;
          end else begin
            time_left <= '0;
            if (display_tick) begin
              blink <= ~blink;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          time_left <= LIMIT;
          running   <= 1'b0;
          timeout   <= 1'b0;
          blink     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: directed round scenarios followed by randomized
// start/pause/slow-clock activity, all checked cycle by cycle against a model.
module tb_game_timer;

  localparam int S  = 2;
  localparam int W  = 8;
  localparam int TL = 5;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSED  = 2;
  localparam int M_TIMEOUT = 3;

  logic         clock       = 1'b0;
  logic         resetn      = 1'b0;
  logic         game_clk    = 1'b0;
  logic         display_clk = 1'b0;
  logic         start       = 1'b0;
  logic         pause       = 1'b0;
  logic         game_tick;
  logic         display_tick;
  logic [W-1:0] time_left;
  logic         running;
  logic         timeout;
  logic         blink;

  int checks = 0;
  int errors = 0;

  // Model: newest-first logs of input samples taken since reset, plus round state
  bit g_log[$];
  bit d_log[$];
  int m_mode;
  int m_tl;
  bit m_blink;

  int slow_mode;
  int gcnt;
  int dcnt;

  always #5 clock = ~clock;

  game_timer #(
    .SYNC_STAGES(S),
    .CNT_W      (W),
    .TIME_LIMIT (TL)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .game_clk    (game_clk),
    .display_clk (display_clk),
    .start       (start),
    .pause       (pause),
    .game_tick   (game_tick),
    .display_tick(display_tick),
    .time_left   (time_left),
    .running     (running),
    .timeout     (timeout),
    .blink       (blink)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A tick is due when the sample taken S edges ago was high and the one before it low
  function automatic bit gtick_m();
    if (g_log.size() < S) return 1'b0;
    if (!g_log[S-1]) return 1'b0;
    return (g_log.size() == S) || !g_log[S];
  endfunction

  function automatic bit dtick_m();
    if (d_log.size() < S) return 1'b0;
    if (!d_log[S-1]) return 1'b0;
    return (d_log.size() == S) || !d_log[S];
  endfunction

  task automatic model_reset();
    g_log.delete();
    d_log.delete();
    m_mode  = M_IDLE;
    m_tl    = TL;
    m_blink = 1'b0;
  endtask

  task automatic model_edge();
    bit gt;
    bit dt;
    gt = gtick_m();
    dt = dtick_m();
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_RUN; m_tl = TL; end
      M_RUN: begin
        if (start) m_tl = TL;
        else if (pause) begin m_mode = M_PAUSED; m_blink = 1'b0; end
        else if (gt) begin
          if (m_tl > 1) m_tl = m_tl - 1;
          else begin m_tl = 0; m_mode = M_TIMEOUT; m_blink = 1'b0; end
        end
      end
      M_PAUSED: begin
        if (start) begin m_mode = M_RUN; m_tl = TL; m_blink = 1'b0; end
        else if (!pause) begin m_mode = M_RUN; m_blink = 1'b0; end
        else if (dt) m_blink = ~m_blink;
      end
      default: begin
        if (start) begin m_mode = M_RUN; m_tl = TL; m_blink = 1'b0; end
        else if (dt) m_blink = ~m_blink;
      end
    endcase
    g_log.push_front(game_clk);
    d_log.push_front(display_clk);
    if (g_log.size() > S + 1) void'(g_log.pop_back());
    if (d_log.size() > S + 1) void'(d_log.pop_back());
  endtask

  task automatic compare_all();
    check("game_tick",    32'(game_tick),    32'(gtick_m()));
    check("display_tick", 32'(display_tick), 32'(dtick_m()));
    check("time_left",    32'(time_left),    32'(m_tl));
    check("running",      32'(running),      32'(m_mode == M_RUN));
    check("timeout",      32'(timeout),      32'(m_mode == M_TIMEOUT));
    check("blink",        32'(blink),        32'(m_blink));
  endtask

  // 0: fixed periods 20/80, 1: random toggling, 2: game_clk held high
  task automatic drive_slow();
    case (slow_mode)
      0: begin
        gcnt++;
        dcnt++;
        game_clk    = (gcnt % 20) >= 10;
        display_clk = (dcnt % 80) >= 40;
      end
      1: begin
        if ($urandom_range(0, 7) == 0)  game_clk    = ~game_clk;
        if ($urandom_range(0, 23) == 0) display_clk = ~display_clk;
      end
      default: game_clk = 1'b1;
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    if (resetn) model_edge();
    @(negedge clock);
    compare_all();
    drive_slow();
  endtask

  task automatic run_until_tl(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (m_tl != target && n < budget) begin
      step();
      n++;
    end
    if (m_tl != target) check(tag, 32'(n), 32'(budget + 1));
  endtask

  task automatic async_reset(input int hold_cycles);
    #2 resetn = 1'b0;
    model_reset();
    #1 compare_all();
    check("rst_time_left", 32'(time_left), 32'(TL));
    check("rst_running",   32'(running),   32'd0);
    check("rst_timeout",   32'(timeout),   32'd0);
    repeat (hold_cycles) step();
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int seen;

    slow_mode = 0;
    gcnt      = 0;
    dcnt      = 0;
    model_reset();

    // Reset state, then idle with game_clk toggling
    repeat (3) @(negedge clock);
    #1 compare_all();
    check("rst_blink", 32'(blink), 32'd0);
    resetn = 1'b1;
    cnt = 0;
    repeat (40) begin
      step();
      if (game_tick) cnt++;
    end
    check("idle_tick_count", 32'(cnt), 32'd2);
    check("idle_time_left", 32'(time_left), 32'(TL));
    check("idle_running", 32'(running), 32'd0);

    // Start pulse, run to timeout, ticks after timeout leave 0
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_running", 32'(running), 32'd1);
    check("start_time_left", 32'(time_left), 32'(TL));
    run_until_tl(0, 200, "wait_timeout1");
    check("timeout_flag", 32'(timeout), 32'd1);
    repeat (60) step();
    check("timeout_hold", 32'(time_left), 32'd0);

    // Pause at 3 for 60 clocks, then resume
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_tl(3, 100, "wait_tl3");
    pause = 1'b1;
    repeat (60) step();
    check("pause_hold", 32'(time_left), 32'd3);
    pause = 1'b0;
    step();
    check("resume_blink", 32'(blink), 32'd0);
    check("resume_running", 32'(running), 32'd1);
    run_until_tl(2, 40, "wait_tl2");
    check("resume_dec", 32'(time_left), 32'd2);

    // Start coincident with a game tick at time_left 2
    cnt = 0;
    while (!(m_tl == 2 && gtick_m()) && cnt < 40) begin step(); cnt++; end
    check("coincide_tick", 32'(game_tick), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("coincide_reload", 32'(time_left), 32'(TL));

    // Pause and start together
    start = 1'b1;
    pause = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b0;
    check("start_pause_run", 32'(running), 32'd1);
    check("start_pause_tl", 32'(time_left), 32'(TL));

    // Blink in TIMEOUT, then restart
    run_until_tl(0, 200, "wait_timeout2");
    seen = 0;
    repeat (170) begin
      step();
      if (blink) seen = 1;
    end
    check("timeout_blink_seen", 32'(seen), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_blink", 32'(blink), 32'd0);
    check("restart_timeout", 32'(timeout), 32'd0);
    check("restart_tl", 32'(time_left), 32'(TL));

    // Async reset mid-round with game_clk held high
    run_until_tl(2, 100, "wait_tl2_rst");
    slow_mode = 2;
    game_clk  = 1'b1;
    async_reset(2);
    cnt = 0;
    repeat (10) begin
      step();
      if (game_tick) cnt++;
    end
    check("held_high_ticks", 32'(cnt), 32'd1);

    // Randomized activity
    slow_mode = 1;
    repeat (4000) begin
      start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      if ($urandom_range(0, 799) == 0) async_reset($urandom_range(1, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
